// File: rtl/sys_arr_feeder.sv
// sys_arr_feeder: skews two 4x4 operand matrices into a 4x4 systolic array,
// one diagonal per slot, followed by zero-bubble drain cycles and a done pulse.
`default_nettype none

module sys_arr_feeder #(
  parameter int WIDTH = 32,
  parameter int DRAIN = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     ready,
  input  logic [7:0]               job_id,
  input  logic [16*WIDTH-1:0]      a_mat,
  input  logic [16*WIDTH-1:0]      b_mat,
  output logic signed [WIDTH-1:0]  A0,
  output logic signed [WIDTH-1:0]  A1,
  output logic signed [WIDTH-1:0]  A2,
  output logic signed [WIDTH-1:0]  A3,
  output logic signed [WIDTH-1:0]  B0,
  output logic signed [WIDTH-1:0]  B1,
  output logic signed [WIDTH-1:0]  B2,
  output logic signed [WIDTH-1:0]  B3,
  output logic [7:0]               tag_0,
  output logic [7:0]               tag_1,
  output logic [7:0]               tag_2,
  output logic [7:0]               tag_3,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FEED  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] FEED_LAST  = 4'd6;
  localparam int         DRAIN_L    = (DRAIN > 0) ? DRAIN - 1 : 0;
  localparam logic [3:0] DRAIN_LAST = DRAIN_L[3:0];

  logic [1:0]            state, state_nx;
  logic [3:0]            t, t_nx;
  logic [16*WIDTH-1:0]   a_reg, b_reg;
  logic [7:0]            id_reg;
  logic                  accept;
  logic [16*WIDTH-1:0]   src_a, src_b;
  logic [7:0]            src_id;
  logic [WIDTH-1:0]      a_q [4];
  logic [WIDTH-1:0]      b_q [4];
  logic [7:0]            tag_q [4];
  logic [WIDTH-1:0]      a_nx [4];
  logic [WIDTH-1:0]      b_nx [4];
  logic [7:0]            tag_nx [4];

  assign accept = start && (state == ST_IDLE) && (job_id != 8'h00);

  always_comb begin
    state_nx = state;
    t_nx     = t;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_FEED;
          t_nx     = 4'd0;
        end
      end
      ST_FEED: begin
        if (t == FEED_LAST) begin
          state_nx = (DRAIN == 0) ? ST_DONE : ST_DRAIN;
          t_nx     = 4'd0;
        end else begin
          t_nx = t + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (t == DRAIN_LAST) begin
          state_nx = ST_DONE;
          t_nx     = 4'd0;
        end else begin
          t_nx = t + 4'd1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        t_nx     = 4'd0;
      end
    endcase
  end

  // Slot values are computed one cycle early from the next slot index so the
  // outputs come straight from registers; on acceptance the live inputs feed slot 0.
  always_comb begin
    src_a  = accept ? a_mat  : a_reg;
    src_b  = accept ? b_mat  : b_reg;
    src_id = accept ? job_id : id_reg;
    for (int r = 0; r < 4; r++) begin
      a_nx[r]   = '0;
      b_nx[r]   = '0;
      tag_nx[r] = '0;
      if (state_nx == ST_FEED) begin
        automatic int k = int'(t_nx) - r;
        if (k >= 0 && k <= 3) begin
          a_nx[r]   = src_a[(r*4+k)*WIDTH +: WIDTH];
          b_nx[r]   = src_b[(k*4+r)*WIDTH +: WIDTH];
          tag_nx[r] = src_id;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      t      <= 4'd0;
      a_reg  <= '0;
      b_reg  <= '0;
      id_reg <= 8'h00;
      for (int r = 0; r < 4; r++) begin
        a_q[r]   <= '0;
        b_q[r]   <= '0;
        tag_q[r] <= '0;
      end
    end else begin
      state <= state_nx;
      t     <= t_nx;
      if (accept) begin
        a_reg  <= a_mat;
        b_reg  <= b_mat;
        id_reg <= job_id;
      end
      for (int r = 0; r < 4; r++) begin
        a_q[r]   <= a_nx[r];
        b_q[r]   <= b_nx[r];
        tag_q[r] <= tag_nx[r];
      end
    end
  end

  assign ready = (state == ST_IDLE) && !reset;
  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);

  assign A0 = a_q[0];
  assign A1 = a_q[1];
  assign A2 = a_q[2];
  assign A3 = a_q[3];
  assign B0 = b_q[0];
  assign B1 = b_q[1];
  assign B2 = b_q[2];
  assign B3 = b_q[3];
  assign tag_0 = tag_q[0];
  assign tag_1 = tag_q[1];
  assign tag_2 = tag_q[2];
  assign tag_3 = tag_q[3];

endmodule

`default_nettype wire

// File: doc/sys_arr_feeder.md
SYS_ARR_FEEDER -- requirements
Module: sys_arr_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width of every A/B element.
REQ-002 SHALL have parameter DRAIN, default 7, meaning zero-bubble cycles issued after the last operand slot.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  job request, sampled on each clk rising edge.
REQ-006 SHALL have port ready  output  1  job accepted when start and ready are both high at a rising edge.
REQ-007 SHALL have port job_id  input  8  tag for the job; 8'h00 is reserved.
REQ-008 SHALL have port a_mat  input  16*WIDTH  a_mat[(r*4+k)*WIDTH +: WIDTH] = A[r][k].
REQ-009 SHALL have port b_mat  input  16*WIDTH  b_mat[(k*4+c)*WIDTH +: WIDTH] = B[k][c].
REQ-010 SHALL have ports A0..A3  output  WIDTH each, signed  skewed row operands into the 4x4 array.
REQ-011 SHALL have ports B0..B3  output  WIDTH each, signed  skewed column operands into the 4x4 array.
REQ-012 SHALL have ports tag_0..tag_3  output  8 each  per-row tag travelling with A.
REQ-013 SHALL have port busy  output  1  high from acceptance until the end of the DONE cycle.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the job's last operand has drained.

Function
REQ-015 SHALL implement the states IDLE, FEED, DRAIN and DONE, with a 4-bit slot counter t.
REQ-016 SHALL assert ready only in IDLE.
REQ-017 SHALL, on acceptance, register a_mat, b_mat and job_id, clear t, and move IDLE->FEED.
REQ-018 SHALL ignore start while job_id==8'h00: no state change, and ready stays high.
REQ-019 SHALL ignore start outside IDLE; registered operands are not disturbed.
REQ-020 SHALL hold FEED for exactly 7 cycles (t=0..6), where t=0 is the first cycle after acceptance.
REQ-021 SHALL drive, for FEED slot t, each row r: A_r=A[r][t-r] and tag_r=job_id when 0<=t-r<=3; otherwise A_r=0 and tag_r=0.
REQ-022 SHALL drive, for FEED slot t, each column c: B_c=B[t-c][c] when 0<=t-c<=3; otherwise B_c=0.
REQ-023 SHALL present the outputs of REQ-021 and REQ-022 from registers: glitch-free and stable for the whole slot cycle.
REQ-024 SHALL, after t=6, enter DRAIN and hold it for DRAIN cycles, driving all A, B and tag outputs to 0.
REQ-025 SHALL enter DONE for exactly 1 cycle, with done=1 and busy=1, and then return to IDLE.
REQ-026 SHALL take exactly 7+DRAIN+1 cycles from acceptance to the return to IDLE; back-to-back jobs have at least 1 IDLE cycle between them.
REQ-027 SHALL, when DRAIN=0, go directly FEED->DONE.
REQ-028 SHALL, in IDLE, drive all A, B and tag outputs to 0, with done=0 and busy=0.
REQ-029 SHALL keep all signed values unmodified; no arithmetic on operands.

Reset
REQ-030 SHALL, on reset assertion at any time (including mid-FEED or mid-DRAIN), immediately force state IDLE, t=0, A0..A3=0, B0..B3=0, tag_0..tag_3=0, busy=0, done=0, ready=1 (once reset is released), and clear the registered matrices and job_id.
REQ-031 SHALL NOT emit done for an aborted job after reset is released.

Verification
REQ-032 SHALL check: A[r][k]=4r+k+1, B[k][c]=17+4k+c, job_id=8'h05, start for 1 cycle -> FEED t=2 gives A0..A3=3,6,9,0, tag=05,05,05,00, B0..B3=25,22,19,0; t=6 gives A3=16, B3=32, all others 0.
REQ-033 SHALL check: a single job with DRAIN=7 -> done is high exactly on cycle 15 after acceptance, busy is high for 15 cycles, and ready returns on cycle 16.
REQ-034 SHALL check: start held high with new data during FEED -> the outputs still match the first job's matrices and the second job is accepted only on the next IDLE cycle.
REQ-035 SHALL check: start with job_id=8'h00 -> no acceptance, busy stays 0, and the outputs stay 0.
REQ-036 SHALL check: reset pulsed at FEED t=3 -> all outputs are 0 in the same cycle, no done follows, and a subsequent job runs with the correct values.
REQ-037 SHALL check: negative operands (A[0][0]=-1, B[0][0]=32'h80000000) -> A0 and B0 carry the exact bit patterns at t=0.
